btn_sw_debounce: RTL
====================

Name: btn_sw_debounce

Overview:
- Input-conditioning stage directly upstream of the Nios II system's i_btn and i_switch PIO ports.
- Synchronises the raw board key and slide-switch pins to clk and debounces each bit independently.
- Provides clean levels, plus one-cycle press/release/change pulses the system can use for edge-capture.
- One instance per board top, inserted between the board pins and the Nios system instance.

Parameters:
- N_BTN, 2: number of push-button inputs.
- N_SW, 10: number of slide-switch inputs.
- DB_CYCLES, 1000000: consecutive stable cycles required to accept a new level. This is 20 ms at 50 MHz. Minimum legal value is 2.
- BTN_ACTIVE_LOW, 1: 1 means a button reads 0 when pressed. This sets the idle level and the press/release sense.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- btn_raw  in  N_BTN  asynchronous key pins.
- sw_raw  in  N_SW  asynchronous switch pins.
- btn_db  out  N_BTN  debounced button level, same polarity as the pins.
- sw_db  out  N_SW  debounced switch level.
- btn_press  out  N_BTN  one-cycle pulse per bit when that button becomes pressed.
- btn_release  out  N_BTN  one-cycle pulse per bit when that button becomes released.
- sw_changed  out  1  one-cycle pulse when any sw_db bit updates.

Behaviour:
- Reset:
  - Reset is synchronous and active-low. It is sampled on the rising edge of clk.
  - While reset_n=0 at an edge: btn_db and both button sync flops load the idle value. Idle is all ones if BTN_ACTIVE_LOW=1, otherwise all zeros.
  - sw_db and the switch sync flops load 0.
  - All counters load 0. btn_press, btn_release and sw_changed load 0.
- Synchroniser:
  - Each bit passes through two flops, s1 then s2. Only s2 is used downstream.
- Per-bit debounce:
  - Each bit has its own counter of width clog2(DB_CYCLES).
  - Each edge, if s2 equals the stable output bit: the counter clears.
  - Otherwise, if the counter equals DB_CYCLES-1: the output bit takes s2 and the counter clears.
  - Otherwise: the counter increments.
  - The counter never wraps. It clears before reaching DB_CYCLES.
- Latency:
  - A raw level first sampled at edge t0, and held, appears on btn_db/sw_db after edge t0+1+DB_CYCLES.
  - With DB_CYCLES=4, that is the 6th edge counting t0 as edge 1.
- Glitches:
  - Any s2 return to the stable value before acceptance clears the counter. The output does not change.
  - A bounce train restarts the count on every return.
- Pulses:
  - Registered in the same edge as the level update, so each is coincident with the first cycle of the new level. Each is high for exactly one cycle.
  - btn_press[i] fires on a transition from the idle level to the pressed level. btn_release[i] fires on the reverse.
  - sw_changed fires if one or more sw_db bits update on that edge. Simultaneous updates give a single pulse.
- Independence:
  - Bits never interact. Simultaneous accepted changes on several buttons give simultaneous pulses on each.
- Reset mid-count:
  - Discards all partial counts. No pulse is asserted on the reset edge or on the first edge after reset release.
  - Post-reset, a raw pin already differing from idle is accepted after the normal latency, with the normal pulse.
- Output stability:
  - All outputs are registered. No combinational path exists from the raw inputs to any output.

Test Plan (DB_CYCLES=4, BTN_ACTIVE_LOW=1):
- Reset: hold reset_n=0 for 3 cycles with btn_raw=2'b11 and sw_raw=0 -> btn_db=2'b11, sw_db=0 and all pulses 0. No pulse in the 10 cycles after release.
- Clean press: btn_raw[0] goes 1->0 and is held -> btn_db[0]=0 and btn_press[0]=1 together after the 6th edge. btn_press[0] is low the next cycle. btn_release stays 0.
- Bounce: btn_raw[1] toggles 0,1,0,1 with 2-cycle periods, then holds 0 -> btn_db[1] changes only 6 edges after the final hold begins. Exactly one btn_press[1] pulse.
- Glitch reject: sw_raw[5] pulses high for 3 cycles -> sw_db stays 0 and sw_changed stays 0.
- Simultaneous switches: sw_raw goes 0 -> 10'h3FF on one edge -> sw_db=10'h3FF after 6 edges, with a single one-cycle sw_changed pulse.
- Reset mid-count: btn_raw[0]=0 for 3 cycles, then assert reset_n=0 for 1 cycle while btn_raw[0] stays 0 -> btn_db[0]=1 and no pulse through reset. btn_db[0]=0 plus btn_press[0] appear the full 6 edges after the first post-reset edge.

Source files
------------

// File: rtl/btn_sw_debounce_if.sv
// Pin-side and system-side signals of the button/switch debouncer.
// The debouncer takes the slave view; the board pins / system take the master view.
interface btn_sw_debounce_if #(
    parameter int N_BTN = 2,
    parameter int N_SW  = 10
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_db;
    logic [N_SW-1:0]  sw_db;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             sw_changed;

    modport master (
        output btn_raw, sw_raw,
        input  btn_db, sw_db, btn_press, btn_release, sw_changed
    );

    modport slave (
        input  btn_raw, sw_raw,
        output btn_db, sw_db, btn_press, btn_release, sw_changed
    );
endinterface

// File: rtl/btn_sw_debounce.sv
// Two-flop synchroniser plus per-bit stable-count debounce for board keys and switches,
// with one-cycle press/release/change pulses aligned to the first cycle of each new level.
module btn_sw_debounce #(
    parameter int N_BTN          = 2,
    parameter int N_SW           = 10,
    parameter int DB_CYCLES      = 1000000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              reset_n,
    btn_sw_debounce_if.slave io
);
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_MAX  = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [N_BTN-1:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    logic [N_BTN-1:0] btn_s1_q, btn_s2_q, btn_db_q, btn_db_d;
    logic [N_BTN-1:0] btn_press_q, btn_press_d, btn_release_q, btn_release_d;
    logic [CW-1:0]    btn_cnt_q [N_BTN];
    logic [CW-1:0]    btn_cnt_d [N_BTN];
    logic [N_SW-1:0]  sw_s1_q, sw_s2_q, sw_db_q, sw_db_d;
    logic             sw_changed_q, sw_changed_d;
    logic [CW-1:0]    sw_cnt_q [N_SW];
    logic [CW-1:0]    sw_cnt_d [N_SW];

    // Button debounce: a bit is accepted once s2 has disagreed with it for DB_CYCLES edges
    always_comb begin
        btn_db_d      = btn_db_q;
        btn_press_d   = {N_BTN{1'b0}};
        btn_release_d = {N_BTN{1'b0}};
        for (int i = 0; i < N_BTN; i++) begin
            btn_cnt_d[i] = {CW{1'b0}};
            if (btn_s2_q[i] == btn_db_q[i]) begin
                btn_cnt_d[i] = {CW{1'b0}};
            end else if (btn_cnt_q[i] == CNT_MAX) begin
                btn_db_d[i]      = btn_s2_q[i];
                btn_press_d[i]   = (btn_s2_q[i] != BTN_IDLE[i]);
                btn_release_d[i] = (btn_s2_q[i] == BTN_IDLE[i]);
            end else begin
                btn_cnt_d[i] = btn_cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Switch debounce: same rule per bit, with a single change pulse for the whole bank
    always_comb begin
        sw_db_d      = sw_db_q;
        sw_changed_d = 1'b0;
        for (int i = 0; i < N_SW; i++) begin
            sw_cnt_d[i] = {CW{1'b0}};
            if (sw_s2_q[i] == sw_db_q[i]) begin
                sw_cnt_d[i] = {CW{1'b0}};
            end else if (sw_cnt_q[i] == CNT_MAX) begin
                sw_db_d[i]   = sw_s2_q[i];
                sw_changed_d = 1'b1;
            end else begin
                sw_cnt_d[i] = sw_cnt_q[i] + CNT_ONE;
            end
        end
    end

    // State registers; reset drops any partial count and returns outputs to idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_s1_q      <= BTN_IDLE;
            btn_s2_q      <= BTN_IDLE;
            btn_db_q      <= BTN_IDLE;
            btn_press_q   <= {N_BTN{1'b0}};
            btn_release_q <= {N_BTN{1'b0}};
            sw_s1_q       <= {N_SW{1'b0}};
            sw_s2_q       <= {N_SW{1'b0}};
            sw_db_q       <= {N_SW{1'b0}};
            sw_changed_q  <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                btn_cnt_q[i] <= {CW{1'b0}};
            end
            for (int i = 0; i < N_SW; i++) begin
                sw_cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            btn_s1_q      <= io.btn_raw;
            btn_s2_q      <= btn_s1_q;
            btn_db_q      <= btn_db_d;
            btn_press_q   <= btn_press_d;
            btn_release_q <= btn_release_d;
            sw_s1_q       <= io.sw_raw;
            sw_s2_q       <= sw_s1_q;
            sw_db_q       <= sw_db_d;
            sw_changed_q  <= sw_changed_d;
            for (int i = 0; i < N_BTN; i++) begin
                btn_cnt_q[i] <= btn_cnt_d[i];
            end
            for (int i = 0; i < N_SW; i++) begin
                sw_cnt_q[i] <= sw_cnt_d[i];
            end
        end
    end

    assign io.btn_db      = btn_db_q;
    assign io.sw_db       = sw_db_q;
    assign io.btn_press   = btn_press_q;
    assign io.btn_release = btn_release_q;
    assign io.sw_changed  = sw_changed_q;
endmodule
